// File: rtl/decrypt_key_scheduler.sv
`default_nettype none
// decrypt_key_scheduler: DES key schedule emitted in decryption order (K16 first),
// one 48-bit subkey per valid/ready handshake. Revision 1.0.
module decrypt_key_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  subkey_round,
  output logic        subkey_last
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_e;

  // Tables hold DES bit numbers (1 = MSB of the source vector).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int j = 0; j < 56; j++) begin
      o[6'(55 - j)] = k[6'(64 - PC1[j])];
    end
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int j = 0; j < 48; j++) begin
      o[6'(47 - j)] = cd[6'(56 - PC2[j])];
    end
    return o;
  endfunction

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic [55:0] pc1_key;
  logic [3:0]  next_round;
  logic        shift_one;

  assign pc1_key    = pc1(key);
  assign next_round = round_q + 4'd1;
  // Undoing the encryption left shifts: single-bit steps land on rounds 1, 8 and 15.
  assign shift_one  = (next_round == 4'd1) || (next_round == 4'd8) || (next_round == 4'd15);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    d_d          = d_q;
    round_d      = round_q;
    key_ready    = 1'b0;
    subkey_valid = 1'b0;
    subkey_last  = 1'b0;
    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          c_d     = pc1_key[55:28];
          d_d     = pc1_key[27:0];
          round_d = 4'd0;
          state_d = GEN;
        end
      end
      GEN: begin
        subkey_valid = 1'b1;
        subkey_last  = (round_q == 4'd15);
        if (subkey_ready) begin
          if (round_q == 4'd15) begin
            state_d = IDLE;
          end else begin
            round_d = next_round;
            c_d     = shift_one ? {c_q[0], c_q[27:1]} : {c_q[1:0], c_q[27:2]};
            d_d     = shift_one ? {d_q[0], d_q[27:1]} : {d_q[1:0], d_q[27:2]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign subkey       = pc2({c_q, d_q});
  assign subkey_round = round_q;

endmodule
`default_nettype wire

// File: doc/decrypt_key_scheduler.md
DECRYPT_KEY_SCHEDULER -- requirements
Module: decrypt_key_scheduler

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have port key, input, 64, raw DES key; key[63] = DES bit 1; parity bits (DES bits 8,16,...,64) ignored.
REQ-004 SHALL have port key_valid, input, 1, key offered.
REQ-005 SHALL have port key_ready, output, 1, block can accept a key.
REQ-006 SHALL have port subkey, output, 48, PC-2 output; subkey[47] = PC-2 bit 1.
REQ-007 SHALL have port subkey_valid, output, 1, subkey/subkey_round/subkey_last are valid.
REQ-008 SHALL have port subkey_ready, input, 1, consumer accepts the current subkey.
REQ-009 SHALL have port subkey_round, output, 4, decryption round index 0..15; index i carries encryption subkey K(16-i).
REQ-010 SHALL have port subkey_last, output, 1, high with the round-15 subkey (K1).

Function
REQ-011 SHALL implement a two-state FSM: IDLE and GEN.
REQ-012 IDLE: key_ready=1, subkey_valid=0.
REQ-013 IDLE, key_valid=1: latch C,D = PC-1(key) (28 bits each), round=0, go to GEN next cycle.
REQ-014 C0/D0 SHALL be used unrotated for round 0, because the total encryption rotation over 16 rounds is 28 bits (C16=C0, D16=D0).
REQ-015 GEN: key_ready=0, subkey_valid=1, subkey=PC-2(C,D), subkey_round=round, subkey_last=(round==15).
REQ-016 Outputs SHALL be driven from registered C/D/round and combinational PC-2 only; there is no added pipeline stage.
REQ-017 GEN, subkey_ready=0: C, D and round SHALL hold, and the outputs SHALL stay stable.
REQ-018 GEN, subkey_ready=1, round<15: C and D SHALL each right-rotate by R(round+1), and round SHALL increment.
REQ-019 The rotation R(r) for the round being entered SHALL be 1 for r in {1,8,15} and 2 for all other r in 1..14.
- This makes the decryption shift sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-020 A right rotate by 1 SHALL move bit 0 to bit 27; a right rotate by 2 SHALL move bits 1:0 to bits 27:26.
REQ-021 GEN, subkey_ready=1, round==15: return to IDLE.
- C, D and round are don't-care after this point.
REQ-022 Latency:
- key handshake at cycle N puts the first subkey valid at N+1.
- With subkey_ready held high, the 16 subkeys SHALL appear on cycles N+1..N+16.
- key_ready SHALL be high again at N+17.
REQ-023 key_valid during GEN SHALL be ignored and SHALL NOT alter the current sequence.
REQ-024 A key SHALL NOT be accepted in the same cycle as the final subkey handshake.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force:
- state=IDLE, round=0, C=0, D=0
- key_ready=1, subkey_valid=0, subkey_last=0, subkey_round=0
REQ-026 Reset asserted mid-GEN SHALL abandon the sequence.
- No further subkeys appear.
- A new key is accepted on the first cycle after rst_n returns high.
REQ-027 With rst_n=0 and key_valid=1 in the same cycle, the key SHALL NOT be accepted.

Verification
REQ-028 Known vector: key=0x133457799BBCDFF1, subkey_ready=1.
- round0 subkey=0xCB3D8B0E17F5 (K16); round1=0xBF918D3D3F0A (K15); round15=0x1B02EFFC7072 (K1).
- subkey_last SHALL be high only on round15.
REQ-029 Parity independence: key=0x123456789ABCDEF0 and the same key with every parity bit inverted SHALL produce an identical 16-subkey sequence.
REQ-030 Backpressure: same key; hold subkey_ready=0 for 5 cycles at round 3.
- subkey and subkey_round=3 SHALL stay stable for those 5 cycles.
- The sequence SHALL resume unchanged on release.
REQ-031 Reset mid-sequence: assert rst_n=0 for 1 cycle at round 7.
- subkey_valid=0 and key_ready=1 on the next cycle.
- A new key SHALL then restart at round 0 with the correct K16.
REQ-032 Back-to-back keys: key_valid held high continuously.
- The second key SHALL be accepted exactly at cycle N+17.
- key_valid asserted during GEN SHALL NOT corrupt the first sequence.
REQ-033 Cross-check: each output subkey_round i SHALL equal the encryption key schedule's subkey 16-i for 32 random keys.
